// File: rtl/spart_pkg.sv
// Shared register-map encodings and status bit positions for the buffered SPART.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DIV_LO = 2'b10,
    ADDR_DIV_HI = 2'b11
  } ioaddr_t;

  localparam int ST_RDA      = 0;
  localparam int ST_TBR      = 1;
  localparam int ST_RX_OVR   = 2;
  localparam int ST_TX_DROP  = 3;
  localparam int ST_TX_EMPTY = 4;
  localparam int ST_RX_FULL  = 5;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous FIFO, head visible combinationally, push/pop take effect at the edge.
// Push while full is accepted only alongside a pop; pop while empty is ignored.
module spart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer distinguishes full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_buffered.sv
// Bus-side SPART: register decode, TX/RX byte FIFOs, sticky error flags, baud divisor.
// Reads are combinational in the access cycle; writes and pops land at the closing edge.
module spart_buffered
  import spart_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  inout  wire  [DATA_W-1:0] databus,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [15:0]       divisor_buffer,
  output logic              rda,
  output logic              tbr
);

  ioaddr_t           addr;
  logic              rd_acc;
  logic              wr_acc;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic              rx_overrun, tx_drop;
  logic              ovr_set, ovr_clr, drop_set, drop_clr;
  logic [7:0]        div_low, div_high;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_data;

  assign addr   = ioaddr_t'(ioaddr);
  assign rd_acc = iocs & iorw;
  assign wr_acc = iocs & ~iorw;

  assign tx_pop  = tx_valid & tx_ready;
  assign tx_push = wr_acc & (addr == ADDR_DATA) & ~rst;
  assign rx_pop  = rd_acc & (addr == ADDR_DATA);
  assign rx_push = rx_valid & ~rst;

  spart_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (databus),
    .pop   (tx_pop),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spart_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (rx_data),
    .pop   (rx_pop),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Stale FIFO contents survive reset, so the head is masked whenever empty.
  assign tx_valid       = ~tx_empty;
  assign tx_data        = tx_empty ? '0 : tx_head;
  assign rda            = ~rx_empty;
  assign tbr            = ~tx_full;
  assign divisor_buffer = {div_high, div_low};

  assign drop_set = tx_push & tx_full & ~tx_pop;
  assign ovr_set  = rx_push & rx_full & ~rx_pop;
  assign drop_clr = wr_acc & (addr == ADDR_STATUS) & databus[ST_TX_DROP];
  assign ovr_clr  = wr_acc & (addr == ADDR_STATUS) & databus[ST_RX_OVR];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
      div_low    <= DIV_RESET[7:0];
      div_high   <= DIV_RESET[15:8];
    end else begin
      rx_overrun <= (rx_overrun & ~ovr_clr) | ovr_set;
      tx_drop    <= (tx_drop & ~drop_clr) | drop_set;
      if (wr_acc && addr == ADDR_DIV_LO) div_low  <= databus[7:0];
      if (wr_acc && addr == ADDR_DIV_HI) div_high <= databus[7:0];
    end
  end

  always_comb begin
    status              = '0;
    status[ST_RDA]      = rda;
    status[ST_TBR]      = tbr;
    status[ST_RX_OVR]   = rx_overrun;
    status[ST_TX_DROP]  = tx_drop;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_DATA:   rd_data = rx_empty ? '0 : rx_head;
      ADDR_STATUS: rd_data = status;
      ADDR_DIV_LO: rd_data[7:0] = div_low;
      ADDR_DIV_HI: rd_data[7:0] = div_high;
      default:     rd_data = '0;
    endcase
  end

  assign databus = rd_acc ? rd_data : 'z;

endmodule

// File: tb/tb_spart_buffered.sv
// Directed bench for spart_buffered with a queue-based reference model checked every cycle.
module tb_spart_buffered;

  localparam int DW  = 8;
  localparam int TXD = 8;
  localparam int RXD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          iocs;
  logic          iorw;
  logic [1:0]    ioaddr;
  wire  [DW-1:0] databus;
  logic          tb_drv;
  logic [DW-1:0] tb_dat;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [15:0]   divisor_buffer;
  logic          rda;
  logic          tbr;

  int checks   = 0;
  int failures = 0;

  assign databus = tb_drv ? tb_dat : 'z;

  always #5 clk = ~clk;

  spart_buffered dut (
    .clk            (clk),
    .rst            (rst),
    .iocs           (iocs),
    .iorw           (iorw),
    .ioaddr         (ioaddr),
    .databus        (databus),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .divisor_buffer (divisor_buffer),
    .rda            (rda),
    .tbr            (tbr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags updated from the bus rules.
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  bit          m_ovr;
  bit          m_drop;
  logic [15:0] m_div;
  bit          m_live = 1'b0;

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s    = 8'h00;
    s[0] = (m_rx.size() > 0);
    s[1] = (m_tx.size() < TXD);
    s[2] = m_ovr;
    s[3] = m_drop;
    s[4] = (m_tx.size() == 0);
    s[5] = (m_rx.size() == RXD);
    return s;
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return (m_rx.size() > 0) ? m_rx[0] : 8'h00;
      2'd1:    return m_status();
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit txp, rxp, tx_wr, tx_ok, rx_ok;
    if (rst) begin
      m_tx.delete();
      m_rx.delete();
      m_ovr  = 1'b0;
      m_drop = 1'b0;
      m_div  = 16'h0000;
      m_live = 1'b1;
    end else begin
      txp   = (m_tx.size() > 0) && tx_ready;
      rxp   = iocs && iorw && (ioaddr == 2'd0) && (m_rx.size() > 0);
      tx_wr = iocs && !iorw && (ioaddr == 2'd0);
      tx_ok = tx_wr && ((m_tx.size() < TXD) || txp);
      rx_ok = rx_valid && ((m_rx.size() < RXD) || rxp);
      if (iocs && !iorw && ioaddr == 2'd1) begin
        if (tb_dat[2]) m_ovr  = 1'b0;
        if (tb_dat[3]) m_drop = 1'b0;
      end
      if (tx_wr && !tx_ok)    m_drop = 1'b1;
      if (rx_valid && !rx_ok) m_ovr  = 1'b1;
      if (txp)   void'(m_tx.pop_front());
      if (tx_ok) m_tx.push_back(tb_dat);
      if (rxp)   void'(m_rx.pop_front());
      if (rx_ok) m_rx.push_back(rx_data);
      if (iocs && !iorw && ioaddr == 2'd2) m_div[7:0]  = tb_dat;
      if (iocs && !iorw && ioaddr == 2'd3) m_div[15:8] = tb_dat;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("tx_valid", tx_valid, m_tx.size() > 0);
      chk("tx_data", tx_data, (m_tx.size() > 0) ? m_tx[0] : 8'h00);
      chk("rda", rda, m_rx.size() > 0);
      chk("tbr", tbr, m_tx.size() < TXD);
      chk("divisor", divisor_buffer, m_div);
      if (iocs && iorw) chk("rd_data", databus, m_read(ioaddr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iocs   = 1'b0;
    iorw   = 1'b0;
    ioaddr = 2'd0;
    tb_drv = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    iocs   = 1'b1;
    iorw   = 1'b0;
    ioaddr = a;
    tb_dat = d;
    tb_drv = 1'b1;
    tick();
    idle();
  endtask

  task automatic rd(input string n, input logic [1:0] a, input logic [7:0] exp);
    iocs   = 1'b1;
    iorw   = 1'b1;
    ioaddr = a;
    tb_drv = 1'b0;
    @(negedge clk);
    chk(n, databus, exp);
    tick();
    idle();
  endtask

  task automatic strobe(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    idle();
    rst      = 1'b1;
    tb_dat   = '0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tbr", tbr, 1'b1);
    chk("rst_rda", rda, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_div", divisor_buffer, 16'h0000);
    rd("rst_status", 2'd1, 8'h12);

    // TX ordering and handshake
    wr(2'd0, 8'h41);
    wr(2'd0, 8'h42);
    wr(2'd0, 8'h43);
    @(negedge clk);
    chk("tx_first_valid", tx_valid, 1'b1);
    chk("tx_first_data", tx_data, 8'h41);
    tx_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("tx_step_42", tx_data, 8'h42);
    tick();
    @(negedge clk);
    chk("tx_step_43", tx_data, 8'h43);
    tick();
    @(negedge clk);
    chk("tx_drained", tx_valid, 1'b0);
    tx_ready = 1'b0;
    rd("tx_empty_status", 2'd1, 8'h12);

    // TX full, drop, sticky clear, write-while-full-with-pop
    for (int i = 0; i < 8; i++) wr(2'd0, 8'h50 + 8'(i));
    @(negedge clk);
    chk("tx_full_tbr", tbr, 1'b0);
    wr(2'd0, 8'hFF);
    rd("tx_drop_status", 2'd1, 8'h08);
    wr(2'd1, 8'h08);
    rd("tx_drop_cleared", 2'd1, 8'h00);
    tx_ready = 1'b1;
    wr(2'd0, 8'h77);
    @(negedge clk);
    chk("tx_full_pop_push_head", tx_data, 8'h51);
    repeat (8) tick();
    @(negedge clk);
    chk("tx_drain_all", tx_valid, 1'b0);
    tx_ready = 1'b0;
    rd("tx_no_drop_status", 2'd1, 8'h12);

    // RX fill, overrun, ordered reads
    for (int i = 0; i < 8; i++) strobe(8'h10 + 8'(i));
    rd("rx_full_status", 2'd1, 8'h33);
    strobe(8'h99);
    rd("rx_ovr_status", 2'd1, 8'h37);
    for (int i = 0; i < 8; i++) rd("rx_pop", 2'd0, 8'h10 + 8'(i));
    @(negedge clk);
    chk("rx_empty_rda", rda, 1'b0);
    rd("rx_empty_read", 2'd0, 8'h00);
    wr(2'd1, 8'h04);
    rd("rx_ovr_cleared", 2'd1, 8'h12);

    // RX full with simultaneous pop and strobe; set-over-clear priority
    for (int i = 0; i < 8; i++) strobe(8'h20 + 8'(i));
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    iocs     = 1'b1;
    iorw     = 1'b1;
    ioaddr   = 2'd0;
    @(negedge clk);
    chk("rx_pop_push_head", databus, 8'h20);
    tick();
    idle();
    rx_valid = 1'b0;
    rd("rx_pop_push_status", 2'd1, 8'h33);
    rx_valid = 1'b1;
    rx_data  = 8'hBB;
    iocs     = 1'b1;
    iorw     = 1'b0;
    ioaddr   = 2'd1;
    tb_dat   = 8'h04;
    tb_drv   = 1'b1;
    tick();
    idle();
    rx_valid = 1'b0;
    rd("set_beats_clear", 2'd1, 8'h37);
    wr(2'd1, 8'h04);
    for (int i = 1; i < 8; i++) rd("rx_pop2", 2'd0, 8'h20 + 8'(i));
    rd("rx_last_aa", 2'd0, 8'hAA);
    rd("rx_empty_again", 2'd1, 8'h12);

    // Divisor
    wr(2'd2, 8'h34);
    wr(2'd3, 8'h12);
    @(negedge clk);
    chk("div_value", divisor_buffer, 16'h1234);
    rd("div_lo_read", 2'd2, 8'h34);
    rd("div_hi_read", 2'd3, 8'h12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("div_reset", divisor_buffer, 16'h0000);

    // Reset mid-operation, with an rx strobe lost in the reset cycle
    wr(2'd0, 8'h61);
    wr(2'd0, 8'h62);
    wr(2'd0, 8'h63);
    strobe(8'h71);
    strobe(8'h72);
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_rda", rda, 1'b0);
    chk("mid_rst_tbr", tbr, 1'b1);
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    rd("mid_rst_status", 2'd1, 8'h12);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_buffered.md
# spart_buffered

Parametrised, FIFO-buffered successor of the SPART bus-interface block. Decodes the processor I/O bus (`iocs`/`iorw`/`ioaddr`/`databus`), buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO, and holds the 16-bit baud divisor. It sits between the processor's I/O bus and the existing `spart_tx`/`spart_rx` serial engines, which attach through the valid/ready ports below.

## Interface
- `DATA_W`, 8: data and bus width; must be ≥ 8.
- `TX_DEPTH`, 8: TX FIFO entries; power of 2, ≥ 2.
- `RX_DEPTH`, 8: RX FIFO entries; power of 2, ≥ 2.
- `DIV_RESET`, 16'h0000: divisor value loaded on reset.

Ports:
- `clk`  in  1  sole clock. One clock; every flop is on `posedge clk`.
- `rst`  in  1  reset, synchronous and active-high.
- `iocs`  in  1  chip select.
- `iorw`  in  1  1 = read, 0 = write.
- `ioaddr`  in  2  register select.
- `databus`  inout  DATA_W  bidirectional processor data.
- `tx_data`  out  DATA_W  TX FIFO head, to the TX engine.
- `tx_valid`  out  1  TX FIFO not empty.
- `tx_ready`  in  1  TX engine idle; a transfer completes on `tx_valid & tx_ready`.
- `rx_data`  in  DATA_W  received byte from the RX engine.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `divisor_buffer`  out  16  `{div_high, div_low}` to both engines.
- `rda`  out  1  RX FIFO not empty.
- `tbr`  out  1  TX FIFO not full.

## Operation
Register map (`ioaddr`):
- `00` read: returns RX head and pops it. Write: pushes `databus` into the TX FIFO.
- `01` read: status. Write: bits set to 1 in positions [2] and [3] clear the matching sticky flags.
- `10` read/write: `div_low`.
- `11` read/write: `div_high`.

Status word, zero-extended to DATA_W:
- [0] `rda`
- [1] `tbr`
- [2] `rx_overrun`, sticky
- [3] `tx_drop`, sticky
- [4] TX empty
- [5] RX full
- [7:6] 0

Bus behaviour:
- `databus` is driven only when `iocs & iorw`; otherwise high-Z.
- A bus access is one cycle long. Each cycle with `iocs` high is one access.
- A read of `00` with RX empty returns 0 and leaves pointers unchanged.
- A write of `00` with TX full is discarded and sets `tx_drop`.
- A TX write in the same cycle as a TX pop while full is accepted; occupancy is unchanged.
- TX pop on `tx_valid & tx_ready`.
- An `rx_valid` strobe with RX full discards the byte and sets `rx_overrun`. Exception: if a bus pop of `00` occurs in the same cycle, push and pop both happen and no overrun is flagged.
- Setting a sticky flag has priority over clearing it in the same cycle.
- Divisor writes take effect next cycle. Divisor values are not range-checked.
- Pointers are log2(DEPTH)+1 bits. Full when MSBs differ and the remaining bits are equal; wrap-around is natural modulo.

Reset (`rst` high at `posedge clk`), applies mid-transfer too:
- FIFOs emptied; FIFO contents are not cleared.
- Sticky flags 0.
- Divisor = `DIV_RESET`.
- Outputs: `tx_valid` 0, `rda` 0, `tbr` 1, `tx_data` 0, `divisor_buffer` = `DIV_RESET`.
- An `rx_valid` strobe coinciding with reset is lost.

## Timing
- Register read data is combinational in the cycle of the read (head, status, divisor). The pop takes effect at the closing edge.
- TX write at edge N: `tx_valid` high and `tx_data` valid after edge N (visible in cycle N+1).
- `rx_valid` at edge N: `rda` high in cycle N+1; status updates at the same point.
- TX empty-to-engine latency: 1 cycle.
- No combinational path from `tx_ready` to `tx_valid`, or from `rx_valid` to `rda`.

## Structure
- `spart_pkg`:
  - `ioaddr_t` enum: `ADDR_DATA`, `ADDR_STATUS`, `ADDR_DIV_LO`, `ADDR_DIV_HI`.
  - Status bit-index localparams: `ST_RDA`, `ST_TBR`, `ST_RX_OVR`, `ST_TX_DROP`, `ST_TX_EMPTY`, `ST_RX_FULL`.
- Sub-module `spart_fifo` (params `WIDTH`, `DEPTH`):
  - Synchronous FIFO with push, pop, `full`, `empty`, `head` outputs.
  - Simultaneous push and pop are legal when full.
  - Instantiated twice, once for TX and once for RX.
- Top level: address decode, status mux, divisor registers, sticky flags, tri-state.

## Test plan
- Reset, then write `0x41`, `0x42`, `0x43` to `00` with `tx_ready`=0 → `tx_valid`=1, `tx_data`=`0x41`. Raise `tx_ready` for 3 cycles → `tx_data` steps `0x42`, `0x43`, then `tx_valid`=0 and status[4]=1.
- Fill TX with 8 writes (`tx_ready`=0) → `tbr`=0. 9th write `0xFF` → dropped, status = `0x08` (TX FIFO non-empty, `tx_drop` set). Write `0x08` to `01` → bit 3 clears.
- 8 `rx_valid` strobes of `0x10`..`0x17` → status[5]=1. 9th strobe `0x99` → `rx_overrun`=1. Reads of `00` return `0x10`..`0x17`, then `0x00`; `rda`=0 after the 8th read.
- RX full, then `rx_valid`=`0xAA` in the same cycle as a read of `00` → read returns the head, no overrun, `0xAA` becomes the last entry.
- Write `0x34` to `10` and `0x12` to `11` → `divisor_buffer`=`16'h1234` next cycle; reads return `0x34`/`0x12`. Assert `rst` → `16'h0000`.
- Reset mid-operation with both FIFOs partly full → next cycle `rda`=0, `tbr`=1, `tx_valid`=0, status = `0x12` (`tbr` and TX-empty set).
